lsu_stage: RTL and testbench

Memory-access stage directly downstream of the execute unit in the single-issue RV32 core. It consumes the execute unit's ALU result, load/store address and store data. It performs loads and stores over a simple request/response data-memory bus and hands a writeback packet to the WBU. Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_stage.sv | 187 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Memory-access stage: issues one load/store at a time on a req/rsp data bus and
// presents a writeback packet; non-memory packets pass straight to DONE.
module lsu_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   res_i,
  input  logic [4:0]        rd_i,
  input  logic              rd_wen_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_rsp_err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_res_o,
  output logic [4:0]        out_rd_o,
  output logic              out_wen_o,
  output logic              out_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_store_q, is_store_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [4:0]          rd_q, rd_d;
  logic                rd_wen_q, rd_wen_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                wen_q, wen_d;
  logic                err_q, err_d;

  function automatic logic access_fault(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic bad_f3, misal;
    bad_f3 = ld ? (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) : (f3 >= 3'b011);
    misal  = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return (ld && st) || bad_f3 || misal;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] rdata);
    logic        [XLEN-1:0] shifted;
    logic signed [7:0]      b8;
    logic signed [15:0]     h16;
    shifted = rdata >> {off, 3'b000};
    b8      = shifted[7:0];
    h16     = shifted[15:0];
    case (f3)
      3'b000:  return XLEN'(b8);
      3'b001:  return XLEN'(h16);
      3'b100:  return {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    res_d      = res_q;
    wen_d      = wen_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          addr_d     = addr_i;
          funct3_d   = funct3_i;
          is_store_d = is_store_i;
          wdata_d    = store_lanes(funct3_i, wdata_i);
          wstrb_d    = is_store_i ? store_strb(funct3_i, addr_i[1:0]) : 4'b0000;
          rd_d       = rd_i;
          rd_wen_d   = rd_wen_i;
          res_d      = '0;
          wen_d      = 1'b0;
          err_d      = 1'b0;
          if (!is_load_i && !is_store_i) begin
            res_d   = res_i;
            wen_d   = rd_wen_i;
            state_d = DONE;
          end else if (access_fault(is_load_i, is_store_i, funct3_i, addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: if (mem_req_ready_i) state_d = WAIT;
      WAIT: begin
        // Store completions and bus errors both leave res/wen at zero.
        if (mem_rsp_valid_i) begin
          state_d = DONE;
          if (mem_rsp_err_i) begin
            err_d = 1'b1;
          end else if (!is_store_q) begin
            res_d = load_extract(funct3_q, addr_q[1:0], mem_rdata_i);
            wen_d = rd_wen_q;
          end
        end
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      res_q      <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      res_q      <= res_d;
      wen_q      <= wen_d;
      err_q      <= err_d;
    end
  end

  // in_ready is masked by reset so it only rises once released into IDLE.
  assign in_ready_o      = (state_q == IDLE) && !rst_i;
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_addr_o      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wen_o       = is_store_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wstrb_o     = wstrb_q;
  assign out_valid_o     = (state_q == DONE);
  assign out_res_o       = res_q;
  assign out_rd_o        = rd_q;
  assign out_wen_o       = wen_q;
  assign out_err_o       = err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: stimulus pushes expected writeback packets into a
// queue, a monitor pops and compares each accepted output packet.
module tb_lsu_stage;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic        is_load_i = 1'b0, is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0, res_i = '0;
  logic [4:0]  rd_i = '0;
  logic        rd_wen_i = 1'b0;
  logic        mem_req_valid_o, mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_wen_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i = 1'b0, mem_rsp_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        out_valid_o, out_ready_i = 1'b1;
  logic [31:0] out_res_o;
  logic [4:0]  out_rd_o;
  logic        out_wen_o, out_err_o;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  lsu_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .res_i(res_i), .rd_i(rd_i), .rd_wen_i(rd_wen_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rdata_i(mem_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_res_o(out_res_o),
    .out_rd_o(out_rd_o), .out_wen_o(out_wen_o), .out_err_o(out_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted output packet must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt", 32'(out_valid_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_res", out_res_o, e.res);
        chk("out_rd", 32'(out_rd_o), 32'(e.rd));
        chk("out_wen", 32'(out_wen_o), 32'(e.wen));
        chk("out_err", 32'(out_err_o), 32'(e.err));
      end
    end
  end

  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] r,
                      input logic [4:0] rd, input logic we, input bit push, input exp_t e);
    int n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready_o), 32'd1);
    is_load_i = ld; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    res_i = r; rd_i = rd; rd_wen_i = we; in_valid_i = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    addr_i = 32'hFFFF_FFFF; res_i = 32'hFFFF_FFFF; wdata_i = 32'hFFFF_FFFF;
  endtask

  task automatic mem_serve(input logic [31:0] ea, input logic ew, input logic [3:0] es,
                           input logic [31:0] ed, input logic [31:0] rdata, input logic rerr,
                           input int dly, input bit pulse);
    int n = 0;
    @(negedge clk_i);
    while (!mem_req_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_seen", 32'(mem_req_valid_o), 32'd1);
    chk("mem_addr", mem_addr_o, ea);
    chk("mem_wen", 32'(mem_wen_o), 32'(ew));
    chk("mem_wstrb", 32'(mem_wstrb_o), 32'(es));
    if (ew) chk("mem_wdata", mem_wdata_o, ed);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk_i);
      #1 mem_rsp_valid_i = pulse && (i == 0);
      mem_rsp_err_i = pulse && (i == 0);
      @(negedge clk_i);
      chk("req_hold_valid", 32'(mem_req_valid_o), 32'd1);
      chk("req_hold_addr", mem_addr_o, ea);
      chk("req_hold_inrdy", 32'(in_ready_o), 32'd0);
      chk("req_hold_outvld", 32'(out_valid_o), 32'd0);
    end
    mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1 mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_err_i = rerr; mem_rdata_i = rdata;
    @(posedge clk_i);
    #1 mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [4:0] rd, input logic we, input logic er);
    exp_t e;
    e.res = r; e.rd = rd; e.wen = we; e.err = er;
    return e;
  endfunction

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_res", out_res_o, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("rel_in_ready", 32'(in_ready_o), 32'd1);

    // ALU passthrough, one-cycle latency
    send(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 1, mk(32'h1234, 5'd5, 1, 0));
    @(negedge clk_i);
    chk("alu_lat", 32'(out_valid_o), 32'd1);
    @(negedge clk_i);
    chk("alu_inrdy_back", 32'(in_ready_o), 32'd1);

    // LB / LBU with zero-wait bus: out_valid three cycles after accept
    send(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h0, 5'd7, 1'b1, 1, mk(32'hFFFF_FF80, 5'd7, 1, 0));
    mem_serve(32'h8000_0000, 0, 4'b0000, 32'h0, 32'h80FF_0000, 0, 0, 0);
    @(negedge clk_i);
    chk("mem_lat", 32'(out_valid_o), 32'd1);
    drain();
    send(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h0, 5'd8, 1'b1, 1, mk(32'h0000_0080, 5'd8, 1, 0));
    mem_serve(32'h8000_0000, 0, 4'b0000, 32'h0, 32'h80FF_0000, 0, 0, 0);
    drain();

    // LH / LHU / LW
    send(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h0, 5'd9, 1'b1, 1, mk(32'hFFFF_8001, 5'd9, 1, 0));
    mem_serve(32'h0000_0100, 0, 4'b0000, 32'h0, 32'h8001_1234, 0, 0, 0);
    drain();
    send(1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h0, 5'd10, 1'b1, 1, mk(32'h0000_F00D, 5'd10, 1, 0));
    mem_serve(32'h0000_0100, 0, 4'b0000, 32'h0, 32'h1234_F00D, 0, 0, 0);
    drain();
    send(1, 0, 3'b010, 32'h0000_0104, 32'h0, 32'h0, 5'd11, 1'b1, 1, mk(32'hCAFE_BABE, 5'd11, 1, 0));
    mem_serve(32'h0000_0104, 0, 4'b0000, 32'h0, 32'hCAFE_BABE, 0, 0, 0);
    drain();

    // Stores: SH, SB, SW
    send(0, 1, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1, 1, mk(32'h0, 5'd3, 0, 0));
    mem_serve(32'h8000_0000, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 0, 0);
    drain();
    send(0, 1, 3'b000, 32'h0000_0041, 32'h1234_5678, 32'h0, 5'd4, 1'b0, 1, mk(32'h0, 5'd4, 0, 0));
    mem_serve(32'h0000_0040, 1, 4'b0010, 32'h7878_7878, 32'h0, 0, 0, 0);
    drain();
    send(0, 1, 3'b010, 32'h0000_0010, 32'hA1B2_C3D4, 32'h0, 5'd6, 1'b1, 1, mk(32'h0, 5'd6, 0, 0));
    mem_serve(32'h0000_0010, 1, 4'b1111, 32'hA1B2_C3D4, 32'h0, 0, 0, 0);
    drain();

    // Backpressure on request and on output; rsp pulse during REQ must be ignored
    out_ready_i = 1'b0;
    send(1, 0, 3'b010, 32'h0000_0020, 32'h0, 32'h0, 5'd12, 1'b1, 1, mk(32'h1122_3344, 5'd12, 1, 0));
    mem_serve(32'h0000_0020, 0, 4'b0000, 32'h0, 32'h1122_3344, 0, 3, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("bp_out_valid", 32'(out_valid_o), 32'd1);
      chk("bp_out_res", out_res_o, 32'h1122_3344);
      chk("bp_in_ready", 32'(in_ready_o), 32'd0);
    end
    @(posedge clk_i);
    #1 out_ready_i = 1'b1;
    drain();

    // Faults: no bus transaction, error packet next cycle
    send(1, 0, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 5'd13, 1'b1, 1, mk(32'h0, 5'd13, 0, 1));
    @(negedge clk_i);
    chk("flt_lw_vld", 32'(out_valid_o), 32'd1);
    chk("flt_lw_noreq", 32'(mem_req_valid_o), 32'd0);
    drain();
    send(1, 0, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 5'd14, 1'b1, 1, mk(32'h0, 5'd14, 0, 1));
    @(negedge clk_i);
    chk("flt_lh_noreq", 32'(mem_req_valid_o), 32'd0);
    drain();
    send(1, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 5'd15, 1'b1, 1, mk(32'h0, 5'd15, 0, 1));
    drain();
    send(0, 1, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 5'd16, 1'b1, 1, mk(32'h0, 5'd16, 0, 1));
    drain();
    send(1, 1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 5'd17, 1'b1, 1, mk(32'h0, 5'd17, 0, 1));
    @(negedge clk_i);
    chk("flt_both_noreq", 32'(mem_req_valid_o), 32'd0);
    drain();

    // Bus error on a load
    send(1, 0, 3'b010, 32'h0000_0030, 32'h0, 32'h0, 5'd18, 1'b1, 1, mk(32'h0, 5'd18, 0, 1));
    mem_serve(32'h0000_0030, 0, 4'b0000, 32'h0, 32'h5555_AAAA, 1, 0, 0);
    drain();

    // Reset while waiting for a response, then a late response is ignored
    send(1, 0, 3'b010, 32'h0000_0050, 32'h0, 32'h0, 5'd19, 1'b1, 0, mk(32'h0, 5'd0, 0, 0));
    @(negedge clk_i);
    chk("rw_req_seen", 32'(mem_req_valid_o), 32'd1);
    mem_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1 mem_req_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 chk("rw_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rw_out_valid", 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1 mem_rsp_valid_i = (i == 0);
      mem_rdata_i = 32'h0BAD_0BAD;
      @(negedge clk_i);
      chk("late_out_valid", 32'(out_valid_o), 32'd0);
      chk("late_in_ready", 32'(in_ready_o), 32'd1);
    end
    mem_rsp_valid_i = 1'b0;
    send(0, 0, 3'b000, 32'h0, 32'h0, 32'h0000_A5A5, 5'd31, 1'b0, 1, mk(32'h0000_A5A5, 5'd31, 0, 0));
    drain();

    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
